// File: rtl/dbus_pkg.sv
// dbus_pkg: shared types, size codes and strobe helper for the data-side AXI bridge
package dbus_pkg;
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} dbus_state_t;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
        return size == SZ_BYTE ? 4'b0001 << addr_lo :
               size == SZ_HALF ? 4'b0011 << addr_lo : 4'b1111;
    endfunction
endpackage

// File: rtl/dbus_axi_bridge_if.sv
// dbus_axi_bridge_if: single-ID AXI3 master channel bundle for the data bridge
interface dbus_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rvalid, awready, wready, bvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/dbus_axi_bridge.sv
// dbus_axi_bridge: one-outstanding SRAM-like data port to single-beat AXI3 master
module dbus_axi_bridge
    import dbus_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [31:0]         data_rdata,
    dbus_axi_bridge_if.master   axi
);
    dbus_state_t state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic        aw_done_q, w_done_q;
    logic        aw_fin, w_fin, rd_done, wr_done;
    assign aw_fin  = aw_done_q | axi.awready;
    assign w_fin   = w_done_q | axi.wready;
    assign rd_done = state_q == RDATA && axi.rvalid;
    assign wr_done = state_q == WRESP && axi.bvalid;
    assign data_addr_ok = !rst && state_q == IDLE && data_req;
    assign data_data_ok = !rst && (rd_done || wr_done);
    assign data_rdata   = (!rst && rd_done) ? axi.rdata : '0;
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = 4'd0;
    assign axi.arburst = 2'b01;
    assign axi.araddr  = addr_q;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arvalid = state_q == RADDR;
    assign axi.rready  = state_q == RDATA;
    assign axi.awid    = AXI_ID;
    assign axi.awlen   = 4'd0;
    assign axi.awburst = 2'b01;
    assign axi.awaddr  = addr_q;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awvalid = state_q == WREQ && !aw_done_q;
    assign axi.wid     = AXI_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = state_q == WREQ && !w_done_q;
    assign axi.bready  = state_q == WRESP;
    // next state: one transaction at a time, stores wait for both AW and W handshakes
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = data_req ? (data_wr ? WREQ : RADDR) : IDLE;
            RADDR:   state_d = axi.arready ? RDATA : RADDR;
            RDATA:   state_d = axi.rvalid ? IDLE : RDATA;
            WREQ:    state_d = (aw_fin && w_fin) ? WRESP : WREQ;
            WRESP:   state_d = axi.bvalid ? IDLE : WRESP;
            default: state_d = IDLE;
        endcase
    end
    // state, captured request and per-channel done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= state_q == WREQ && state_d == WREQ && aw_fin;
            w_done_q  <= state_q == WREQ && state_d == WREQ && w_fin;
            if (state_q == IDLE && data_req) begin
                addr_q  <= data_addr;
                wdata_q <= data_wdata;
                size_q  <= data_size;
                wstrb_q <= gen_wstrb(data_size, data_addr[1:0]);
            end
        end
    end
endmodule

// File: tb/tb_dbus_axi_bridge.sv
// tb_dbus_axi_bridge: directed AXI slave stimulus with a completion scoreboard
module tb_dbus_axi_bridge;
    import dbus_pkg::*;
    logic        clk = 1'b0;
    logic        rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] next_rdata;
    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    typedef struct {logic wr; logic [31:0] rdata;} exp_t;
    exp_t sb[$];
    dbus_axi_bridge_if axi();
    dbus_axi_bridge #(.AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .axi(axi)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic neg;
        @(negedge clk);
    endtask
    function automatic logic [4:0] valids;
        return {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready};
    endfunction
    // scoreboard: expectation pushed on acceptance, popped on completion
    always @(negedge clk) begin
        if (data_addr_ok) sb.push_back(exp_t'{wr: data_wr, rdata: next_rdata});
        if (data_data_ok) begin
            n_done++;
            check("sb_nonempty_on_data_ok", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                if (!e.wr) check("load_rdata", data_rdata, e.rdata);
            end
        end
    end
    initial begin
        rst = 1; data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0; next_rdata = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        repeat (2) tick;
        data_req = 1;
        neg;
        check("rst_valids", 32'(valids()), 0);
        check("rst_addr_ok", 32'(data_addr_ok), 0);
        check("rst_araddr", axi.araddr, 0);
        check("rst_wstrb", 32'(axi.wstrb), 0);
        tick; rst = 0; data_req = 0;
        neg;
        check("post_rst_outs", 32'({valids(), data_addr_ok, data_data_ok}), 0);
        // load word, minimum latency
        tick; data_req = 1; data_wr = 0; data_size = SZ_WORD; data_addr = 32'h1000_0004;
        next_rdata = 32'hDEAD_BEEF; axi.arready = 1; axi.rvalid = 1; axi.rdata = 32'hDEAD_BEEF;
        neg;
        check("t1_addr_ok", 32'(data_addr_ok), 1);
        check("t1_idle_no_consume", 32'({data_data_ok, axi.rready}), 0);
        tick; data_req = 0; data_addr = 0;
        neg;
        check("t1_arvalid", 32'(axi.arvalid), 1);
        check("t1_araddr", axi.araddr, 32'h1000_0004);
        check("t1_arsize", 32'(axi.arsize), 2);
        check("t1_c1_oks", 32'({data_addr_ok, data_data_ok}), 0);
        tick;
        neg;
        check("t1_c2_data_ok", 32'(data_data_ok), 1);
        check("t1_c2_valids", 32'(valids()), 5'b01000);
        tick; axi.rvalid = 0; axi.arready = 0;
        neg;
        check("t1_idle", 32'({valids(), data_data_ok}), 0);
        // store byte at lane 3
        tick; data_req = 1; data_wr = 1; data_size = SZ_BYTE; data_addr = 32'h2000_0003;
        data_wdata = 32'h5A5A_5A5A; axi.awready = 1; axi.wready = 1;
        neg;
        check("t2_addr_ok", 32'(data_addr_ok), 1);
        tick; data_req = 0;
        neg;
        check("t2_c1_valids", 32'(valids()), 5'b00110);
        check("t2_awaddr", axi.awaddr, 32'h2000_0003);
        check("t2_awsize", 32'(axi.awsize), 0);
        check("t2_wstrb", 32'(axi.wstrb), 4'b1000);
        check("t2_wdata", axi.wdata, 32'h5A5A_5A5A);
        tick; axi.bvalid = 1;
        neg;
        check("t2_c2_valids", 32'(valids()), 5'b00001);
        check("t2_data_ok", 32'(data_data_ok), 1);
        tick; axi.bvalid = 0; axi.awready = 0; axi.wready = 0;
        neg;
        check("t2_idle", 32'({valids(), data_data_ok}), 0);
        // store half, W handshake before AW
        tick; data_req = 1; data_wr = 1; data_size = SZ_HALF; data_addr = 32'h3000_0002;
        data_wdata = 32'h1234_1234; axi.wready = 1;
        neg;
        check("t3_addr_ok", 32'(data_addr_ok), 1);
        tick; data_req = 0;
        neg;
        check("t3_c1_valids", 32'(valids()), 5'b00110);
        check("t3_wstrb", 32'(axi.wstrb), 4'b1100);
        check("t3_awsize", 32'(axi.awsize), 1);
        tick; axi.wready = 0; axi.bvalid = 1;
        neg;
        check("t3_w_dropped", 32'(valids()), 5'b00100);
        check("t3_early_b_ignored", 32'(data_data_ok), 0);
        tick; axi.bvalid = 0; axi.awready = 1;
        neg;
        check("t3_aw_pending", 32'(valids()), 5'b00100);
        tick; axi.awready = 0; axi.bvalid = 1;
        neg;
        check("t3_wresp", 32'(valids()), 5'b00001);
        check("t3_data_ok", 32'(data_data_ok), 1);
        tick; axi.bvalid = 0;
        neg;
        check("t3_idle", 32'({valids(), data_data_ok}), 0);
        // load stalled by arready, second request held off
        tick; data_req = 1; data_wr = 0; data_size = SZ_WORD; data_addr = 32'h4000_0010;
        next_rdata = 32'h0BAD_F00D;
        neg;
        check("t4_addr_ok", 32'(data_addr_ok), 1);
        tick; data_addr = 32'h4444_4444;
        for (int i = 0; i < 5; i++) begin
            neg;
            check("t4_stall_arvalid", 32'(axi.arvalid), 1);
            check("t4_stall_araddr", axi.araddr, 32'h4000_0010);
            check("t4_stall_addr_ok", 32'(data_addr_ok), 0);
            tick;
        end
        data_req = 0; axi.arready = 1;
        neg;
        check("t4_arvalid", 32'(axi.arvalid), 1);
        tick; axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h0BAD_F00D;
        neg;
        check("t4_data_ok", 32'(data_data_ok), 1);
        // back-to-back loads
        tick; axi.rvalid = 0; data_req = 1; data_addr = 32'h5000_0000; next_rdata = 32'h1111_1111;
        axi.arready = 1;
        neg;
        check("t5_b2b_addr_ok", 32'(data_addr_ok), 1);
        tick; data_addr = 32'h5000_0004; axi.rvalid = 1; axi.rdata = 32'h1111_1111;
        neg;
        check("t5_raddr", 32'({axi.arvalid, data_addr_ok, data_data_ok}), 3'b100);
        tick;
        neg;
        check("t5_first_done", 32'({data_addr_ok, data_data_ok}), 2'b01);
        tick; next_rdata = 32'h2222_2222; axi.rdata = 32'h2222_2222;
        neg;
        check("t5_b2b2_addr_ok", 32'(data_addr_ok), 1);
        tick; data_req = 0;
        neg;
        check("t5_araddr2", axi.araddr, 32'h5000_0004);
        tick;
        neg;
        check("t5_second_done", 32'(data_data_ok), 1);
        tick; axi.rvalid = 0; axi.arready = 0;
        neg;
        check("t5_idle", 32'({valids(), data_data_ok}), 0);
        // reset while waiting in WRESP
        tick; data_req = 1; data_wr = 1; data_size = SZ_WORD; data_addr = 32'h6000_0009;
        data_wdata = 32'hCAFE_F00D; axi.awready = 1; axi.wready = 1;
        neg;
        check("t6_addr_ok", 32'(data_addr_ok), 1);
        tick; data_req = 0;
        neg;
        check("t6_wstrb", 32'(axi.wstrb), 4'b1111);
        tick; axi.awready = 0; axi.wready = 0;
        neg;
        check("t6_wresp", 32'({valids(), data_data_ok}), 6'b000010);
        tick; rst = 1; axi.bvalid = 1;
        neg;
        check("t6_rst_no_data_ok", 32'(data_data_ok), 0);
        tick; rst = 0; sb.delete();
        neg;
        check("t6_after_rst", 32'({valids(), data_addr_ok, data_data_ok}), 0);
        tick; axi.bvalid = 0; data_req = 1; data_wr = 0; data_addr = 32'h7000_0000;
        next_rdata = 32'h7777_0000;
        neg;
        check("t6_idle_accept", 32'(data_addr_ok), 1);
        tick; data_req = 0; axi.arready = 1;
        neg;
        check("t6_arvalid", 32'(axi.arvalid), 1);
        tick; axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h7777_0000;
        neg;
        check("t6_data_ok", 32'(data_data_ok), 1);
        tick; axi.rvalid = 0;
        neg;
        check("sb_drained", 32'(sb.size()), 0);
        check("completions", 32'(n_done), 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
